mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch requester (imem) and the data requester (dmem) of the RV32I pipeline.
- Each pipeline step may carry one imem request, one dmem request, or both. The arbiter latches them, serializes them onto the memory port, and returns a per-requester response pulse.
- It pulses go once all requests of the step are complete; the pipeline advances only on go.

Parameters:
- DMEM_FIRST, 1: 1 = serve dmem before imem when both are pending; 0 = serve imem first.
- CNT_W, 32: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- imem_addr  in  32  fetch address
- imem_rmask  in  4  fetch read mask; nonzero = request
- imem_rdata  out  32  fetch data, registered
- imem_resp  out  1  one-cycle fetch-complete pulse
- dmem_addr  in  32  data address
- dmem_rmask  in  4  data read mask
- dmem_wmask  in  4  data write mask; request = (rmask|wmask) != 0
- dmem_wdata  in  32  store data
- dmem_rdata  out  32  load data, registered
- dmem_resp  out  1  one-cycle data-complete pulse
- mem_addr  out  32  memory address
- mem_rmask  out  4  memory read strobe/mask
- mem_wmask  out  4  memory write strobe/mask
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_resp
- mem_resp  in  1  memory completion; arrives at least 1 cycle after the strobe
- go  out  1  one-cycle step-complete pulse
- stall_cnt  out  CNT_W  saturating count of cycles with state != IDLE

Behaviour:
- Reset (async, rst=1): every output is 0 immediately.
  - State = IDLE; pending flags and latched requests are cleared.
  - rdata registers = 0; stall_cnt = 0.
  - An in-flight memory transaction is abandoned, and a later mem_resp for it is ignored.
- States: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE.
- IDLE:
  - If imem and/or dmem requests, latch addr, masks and wdata for each, and set i_pend/d_pend.
  - Next state = first-served requester's REQ state: per DMEM_FIRST when both are pending, otherwise the sole requester.
  - With no request, stay in IDLE; go = 0.
- Requests presented while state != IDLE are ignored. Upstream holds new requests until after go.
- D_REQ / I_REQ (exactly 1 cycle):
  - mem_addr/mem_rmask/mem_wmask/mem_wdata are driven from the latched request; next state = matching WAIT.
  - imem requests drive mem_wmask = 0 and mem_wdata = 0.
- Outside REQ states, mem_rmask = mem_wmask = 0. mem_addr and mem_wdata are 0.
- D_WAIT / I_WAIT:
  - Wait for mem_resp. On mem_resp, register mem_rdata into that requester's rdata and clear its pend flag.
  - The matching *_resp is 1 on the next cycle.
  - Next state = the other requester's REQ if its pend flag is still set, else DONE.
- mem_resp in IDLE, REQ or DONE is ignored. A write-only dmem request still captures mem_rdata; its value is don't-care.
- DONE (1 cycle): go = 1, coincident with the final *_resp pulse; next state = IDLE.
- rdata outputs hold their value until the next capture.
- *_resp pulses last exactly one cycle each; each is asserted once per request.
- Latency, memory response L cycles after the strobe, step accepted at cycle 0:
  - Single request: strobe at cycle 1, resp/go at cycle 2+L.
  - Dual requests: first resp at 2+L1, second strobe at 2+L1, second resp and go at 3+L1+L2.
- stall_cnt increments each cycle with state != IDLE and saturates at all-ones. It does not wrap.

Test Plan:
- Reset mid-D_WAIT, then mem_resp 2 cycles later:
  - All outputs 0 immediately; state IDLE.
  - The late mem_resp produces no dmem_resp or go.
- imem-only fetch: imem_addr=0x6000_0000, rmask=0xF; memory L=1, mem_rdata=0x0000_0013.
  - Strobe at cycle 1 with mem_addr=0x6000_0000, mem_rmask=0xF, mem_wmask=0.
  - At cycle 3: imem_rdata=0x0000_0013, imem_resp=1, go=1; stall_cnt=3.
- Dual request, DMEM_FIRST=1: imem at 0x6000_0004; dmem load at 0x6000_1000, rmask=0xF; L=2 each.
  - dmem strobe at cycle 1, dmem_resp at cycle 4.
  - imem strobe at cycle 4, imem_resp and go at cycle 7.
  - Exactly one pulse of each resp.
- Store-only dmem: wmask=0x3, wdata=0xDEAD_BEEF, addr=0x6000_2000.
  - Strobe carries mem_wmask=0x3, mem_rmask=0, mem_wdata=0xDEAD_BEEF; dmem_resp and go follow mem_resp.
- DMEM_FIRST=0 dual request: imem is strobed first. A new imem request presented in I_WAIT is ignored.
- stall_cnt saturation with CNT_W=4: run 20 busy cycles -> stall_cnt stays at 0xF, with no wrap to 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and unified-memory buses around the arbiter.
// slave is the arbiter's view; master is the pipeline/memory side.
interface mem_arbiter_if;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           mem_rdata, mem_resp,
    input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
           mem_addr, mem_rmask, mem_wmask, mem_wdata
  );

  modport slave (
    input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
           mem_rdata, mem_resp,
    output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
           mem_addr, mem_rmask, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serializes one pipeline step's imem/dmem requests onto the single memory port
// and pulses go when every request of the step has completed.
module mem_arbiter #(
  parameter int DMEM_FIRST = 1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_if.slave     bus,
  output logic             go,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [2:0] {IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic        i_req, d_req;
  logic        i_pend_q, d_pend_q;
  logic [31:0] i_addr_q, d_addr_q, d_wdata_q;
  logic [3:0]  i_rmask_q, d_rmask_q, d_wmask_q;
  logic [31:0] imem_rdata_q, dmem_rdata_q;
  logic        imem_resp_q, dmem_resp_q;
  logic [CNT_W-1:0] stall_q;

  assign i_req = |bus.imem_rmask;
  assign d_req = |(bus.dmem_rmask | bus.dmem_wmask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req && ((DMEM_FIRST != 0) || !i_req)) state_d = D_REQ;
        else if (i_req)                              state_d = I_REQ;
      end
      D_REQ:  state_d = D_WAIT;
      D_WAIT: if (bus.mem_resp) state_d = i_pend_q ? I_REQ : DONE;
      I_REQ:  state_d = I_WAIT;
      I_WAIT: if (bus.mem_resp) state_d = d_pend_q ? D_REQ : DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes exist only in the one-cycle REQ states; the bus is zero otherwise.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_rmask = '0;
    bus.mem_wmask = '0;
    bus.mem_wdata = '0;
    case (state_q)
      D_REQ: begin
        bus.mem_addr  = d_addr_q;
        bus.mem_rmask = d_rmask_q;
        bus.mem_wmask = d_wmask_q;
        bus.mem_wdata = d_wdata_q;
      end
      I_REQ: begin
        bus.mem_addr  = i_addr_q;
        bus.mem_rmask = i_rmask_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_pend_q     <= 1'b0;
      d_pend_q     <= 1'b0;
      i_addr_q     <= '0;
      i_rmask_q    <= '0;
      d_addr_q     <= '0;
      d_rmask_q    <= '0;
      d_wmask_q    <= '0;
      d_wdata_q    <= '0;
      imem_rdata_q <= '0;
      dmem_rdata_q <= '0;
      imem_resp_q  <= 1'b0;
      dmem_resp_q  <= 1'b0;
      stall_q      <= '0;
    end else begin
      imem_resp_q <= 1'b0;
      dmem_resp_q <= 1'b0;
      // Counts the cycle being entered, so the value shown includes the current busy cycle.
      if (state_d != IDLE && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + 1'b1;
      case (state_q)
        IDLE: begin
          i_pend_q  <= i_req;
          d_pend_q  <= d_req;
          i_addr_q  <= bus.imem_addr;
          i_rmask_q <= bus.imem_rmask;
          d_addr_q  <= bus.dmem_addr;
          d_rmask_q <= bus.dmem_rmask;
          d_wmask_q <= bus.dmem_wmask;
          d_wdata_q <= bus.dmem_wdata;
        end
        D_WAIT: if (bus.mem_resp) begin
          dmem_rdata_q <= bus.mem_rdata;
          d_pend_q     <= 1'b0;
          dmem_resp_q  <= 1'b1;
        end
        I_WAIT: if (bus.mem_resp) begin
          imem_rdata_q <= bus.mem_rdata;
          i_pend_q     <= 1'b0;
          imem_resp_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_rdata = imem_rdata_q;
  assign bus.dmem_rdata = dmem_rdata_q;
  assign bus.imem_resp  = imem_resp_q;
  assign bus.dmem_resp  = dmem_resp_q;
  assign go             = (state_q == DONE);
  assign stall_cnt      = stall_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (dmem-first, imem-first, 4-bit counter)
// share stimulus; each has its own latency-programmable memory responder.
module tb_mem_arbiter;
  localparam int     PF[3]   = '{1, 0, 1};
  localparam longint SMAX[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hF};

  logic clk = 1'b0;
  logic rst;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  i_rmask, d_rmask, d_wmask;

  logic [31:0] o_addr [3];
  logic [31:0] o_wdata[3];
  logic [31:0] o_ird  [3];
  logic [31:0] o_drd  [3];
  logic [31:0] o_st   [3];
  logic [3:0]  o_rm   [3];
  logic [3:0]  o_wm   [3];
  logic        o_ir   [3];
  logic        o_dr   [3];
  logic        o_go   [3];

  logic        mresp[3] = '{1'b0, 1'b0, 1'b0};
  logic [31:0] mrd  [3] = '{32'h0, 32'h0, 32'h0};
  int          rcnt [3] = '{0, 0, 0};
  int          sidx [3] = '{0, 0, 0};
  int          sstep[3] = '{-1, -1, -1};
  logic [31:0] raddr[3] = '{32'h0, 32'h0, 32'h0};
  int lat1, lat2, step_id;

  int tests, fails, base;
  logic [31:0] exp_ird[3], exp_drd[3];

  mem_arbiter_if bus[3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CW = (g == 2) ? 4 : 32;
    logic [CW-1:0] sc;
    assign bus[g].imem_addr  = i_addr;
    assign bus[g].imem_rmask = i_rmask;
    assign bus[g].dmem_addr  = d_addr;
    assign bus[g].dmem_rmask = d_rmask;
    assign bus[g].dmem_wmask = d_wmask;
    assign bus[g].dmem_wdata = d_wdata;
    assign bus[g].mem_resp   = mresp[g];
    assign bus[g].mem_rdata  = mrd[g];
    assign o_addr[g]  = bus[g].mem_addr;
    assign o_wdata[g] = bus[g].mem_wdata;
    assign o_rm[g]    = bus[g].mem_rmask;
    assign o_wm[g]    = bus[g].mem_wmask;
    assign o_ird[g]   = bus[g].imem_rdata;
    assign o_drd[g]   = bus[g].dmem_rdata;
    assign o_ir[g]    = bus[g].imem_resp;
    assign o_dr[g]    = bus[g].dmem_resp;
    assign o_st[g]    = 32'(sc);
    mem_arbiter #(.DMEM_FIRST(PF[g]), .CNT_W(CW)) u_dut (
      .clk(clk), .rst(rst), .bus(bus[g]), .go(o_go[g]), .stall_cnt(sc)
    );
  end

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h6000_0000) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'hC3C3_0F0F;
  endfunction

  // Memory model: a strobe seen in cycle s answers in cycle s+L (L = lat1 for the
  // step's first strobe, lat2 for the second); rdata is garbage when not responding.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rcnt[i] > 0) rcnt[i] = rcnt[i] - 1;
      if ((o_rm[i] | o_wm[i]) != 4'h0) begin
        if (sstep[i] != step_id) begin sstep[i] = step_id; sidx[i] = 0; end
        rcnt[i]  = (sidx[i] == 0) ? lat1 : lat2;
        raddr[i] = o_addr[i];
        sidx[i]  = sidx[i] + 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      mresp[i] = (rcnt[i] == 1);
      mrd[i]   = (rcnt[i] == 1) ? memval(raddr[i]) : $urandom();
    end
  end

  task automatic zero_inputs();
    i_addr = '0; i_rmask = '0; d_addr = '0; d_rmask = '0; d_wmask = '0; d_wdata = '0;
  endtask

  // One pipeline step; expected per-cycle behaviour derived from the latency rules.
  task automatic run_step(input bit ir, input bit dr, input logic [31:0] ia, input logic [3:0] irm,
                          input logic [31:0] da, input logic [3:0] drm, input logic [3:0] dwm,
                          input logic [31:0] dwd, input int l1, input int l2, input bit junk);
    int n, done;
    n    = (ir && dr) ? 2 : 1;
    done = (n == 2) ? 3 + l1 + l2 : 2 + l1;
    for (int c = 0; c <= done + 1; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        step_id++; lat1 = l1; lat2 = l2;
        i_addr = ia; i_rmask = ir ? irm : 4'h0;
        d_addr = da; d_rmask = dr ? drm : 4'h0; d_wmask = dr ? dwm : 4'h0; d_wdata = dwd;
      end else if (junk && c < done) begin
        i_addr = $urandom(); i_rmask = 4'($urandom_range(1, 15));
        d_addr = $urandom(); d_rmask = 4'($urandom_range(1, 15));
        d_wmask = 4'($urandom_range(0, 15)); d_wdata = $urandom();
      end else zero_inputs();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        bit dfirst, sd, si;
        int s2, irc, drc, cyc;
        longint est;
        logic [103:0] e_bus, a_bus;
        logic [2:0] e_rsp, a_rsp;
        dfirst = dr && ((PF[k] != 0) || !ir);
        s2 = (n == 2) ? 2 + l1 : -1;
        if (dfirst) begin drc = 2 + l1; irc = ir ? 3 + l1 + l2 : -1; end
        else        begin irc = 2 + l1; drc = dr ? 3 + l1 + l2 : -1; end
        sd = (dfirst && c == 1) || (!dfirst && c == s2);
        si = (!dfirst && c == 1) || (dfirst && c == s2);
        if (sd)      e_bus = {da, drm, dwm, dwd, 32'h0};
        else if (si) e_bus = {ia, irm, 4'h0, 32'h0, 32'h0};
        else         e_bus = '0;
        a_bus = {o_addr[k], o_rm[k], o_wm[k], o_wdata[k], 32'h0};
        tests++;
        if (a_bus !== e_bus) begin
          fails++;
          $display("FAIL strobe inst%0d cyc%0d: got addr/rm/wm/wd=%h, want %h", k, c, a_bus[103:32], e_bus[103:32]);
        end
        if (c == irc) exp_ird[k] = memval(ia);
        if (c == drc) exp_drd[k] = memval(da);
        e_rsp = {c == irc, c == drc, c == done};
        a_rsp = {o_ir[k], o_dr[k], o_go[k]};
        tests++;
        if (a_rsp !== e_rsp) begin
          fails++;
          $display("FAIL resp inst%0d cyc%0d: got iresp/dresp/go=%b, want %b", k, c, a_rsp, e_rsp);
        end
        tests++;
        if (o_ird[k] !== exp_ird[k] || o_drd[k] !== exp_drd[k]) begin
          fails++;
          $display("FAIL rdata inst%0d cyc%0d: got i=%h d=%h, want i=%h d=%h", k, c, o_ird[k], o_drd[k], exp_ird[k], exp_drd[k]);
        end
        cyc = (c == 0) ? 0 : ((c > done) ? done : c);
        est = longint'(base + cyc);
        if (est > SMAX[k]) est = SMAX[k];
        tests++;
        if (o_st[k] !== 32'(est)) begin
          fails++;
          $display("FAIL stall_cnt inst%0d cyc%0d: got %0d, want %0d", k, c, o_st[k], est);
        end
      end
    end
    base += done;
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({o_addr[k], o_rm[k], o_wm[k], o_wdata[k], o_ird[k], o_drd[k], o_ir[k], o_dr[k], o_go[k], o_st[k]} !== '0) begin
        fails++;
        $display("FAIL %s inst%0d: got addr=%h rm=%h wm=%h wd=%h ird=%h drd=%h ir=%b dr=%b go=%b st=%0d, want all 0",
                 tag, k, o_addr[k], o_rm[k], o_wm[k], o_wdata[k], o_ird[k], o_drd[k], o_ir[k], o_dr[k], o_go[k], o_st[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; zero_inputs();
    repeat (2) @(posedge clk);
    #2 check_all_zero("reset_initial");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    step_id++; lat1 = 4; lat2 = 4;
    d_addr = 32'h6000_1040; d_rmask = 4'hF;
    @(posedge clk); #1 zero_inputs();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (o_rm[k] !== 4'hF || o_addr[k] !== 32'h6000_1040) begin
        fails++;
        $display("FAIL reset_pre_strobe inst%0d: got rm=%h addr=%h, want rm=f addr=60001040", k, o_rm[k], o_addr[k]);
      end
    end
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    #1 check_all_zero("reset_async");
    @(posedge clk); #1 rst = 1'b0;
    base = 0;
    for (int k = 0; k < 3; k++) begin exp_ird[k] = '0; exp_drd[k] = '0; end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_all_zero("reset_late_resp");
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  task automatic test_imem_fetch();
    run_step(1'b1, 1'b0, 32'h6000_0000, 4'hF, 32'h0, 4'h0, 4'h0, 32'h0, 1, 1, 1'b0);
    tests++;
    if (o_ird[0] !== 32'h0000_0013) begin
      fails++;
      $display("FAIL imem_fetch_rdata: got %h, want 00000013", o_ird[0]);
    end
  endtask

  task automatic test_dual();
    run_step(1'b1, 1'b1, 32'h6000_0004, 4'hF, 32'h6000_1000, 4'hF, 4'h0, 32'h0, 2, 2, 1'b0);
  endtask

  task automatic test_store();
    run_step(1'b0, 1'b1, 32'h0, 4'h0, 32'h6000_2000, 4'h0, 4'h3, 32'hDEAD_BEEF, 2, 1, 1'b0);
  endtask

  task automatic test_dmem_first0();
    run_step(1'b1, 1'b1, 32'h6000_0008, 4'hF, 32'h6000_3000, 4'h3, 4'h0, 32'h0, 3, 1, 1'b1);
  endtask

  task automatic test_saturation();
    run_step(1'b1, 1'b1, 32'h6000_000C, 4'hF, 32'h6000_4000, 4'hF, 4'hF, 32'h1234_5678, 4, 4, 1'b0);
    run_step(1'b1, 1'b1, 32'h6000_0010, 4'hF, 32'h6000_4004, 4'hF, 4'h0, 32'h0, 4, 3, 1'b0);
    tests++;
    if (o_st[2] !== 32'hF || o_st[0] !== 32'(base)) begin
      fails++;
      $display("FAIL stall_saturate: got cnt4=%0d cnt32=%0d, want 15 and %0d", o_st[2], o_st[0], base);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 30; s++) begin
      int sel;
      logic [3:0] drm, dwm;
      sel = $urandom_range(1, 3);
      drm = 4'($urandom_range(0, 15));
      dwm = (drm == 4'h0) ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
      run_step(sel[0], sel[1], $urandom(), 4'($urandom_range(1, 15)), $urandom(), drm, dwm, $urandom(),
               $urandom_range(1, 4), $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; base = 0; step_id = 0; lat1 = 1; lat2 = 1;
    for (int k = 0; k < 3; k++) begin exp_ird[k] = '0; exp_drd[k] = '0; end
    test_reset();
    test_imem_fetch();
    test_dual();
    test_store();
    test_dmem_first0();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
